// File: rtl/ratio_pkg.sv
// Shared constants and state encoding for the ratio frame buffer.
package ratio_pkg;

  localparam int unsigned RATIO_DATA_W = 12;
  localparam int unsigned RATIO_IDX_W  = 11;
  localparam int unsigned RATIO_DEPTH  = 2048;
  localparam int unsigned ABORT_W      = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/ratio_frame_ram.sv
// Simple dual-port frame store: one write port, one read port with a registered output.
// rdata holds its value while re is low, so a stalled reader can rely on it.
module ratio_frame_ram
  import ratio_pkg::*;
#(
  parameter int unsigned DATA_W = RATIO_DATA_W,
  parameter int unsigned ADDR_W = RATIO_IDX_W,
  parameter int unsigned DEPTH  = RATIO_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ratio_frame_buffer.sv
// Collects one frame of averaged quotients, then streams it out over valid/ready.
// Optional running-peak tracker enabled by defining RATIO_FRAME_PEAK_EN.
module ratio_frame_buffer
  import ratio_pkg::*;
#(
  parameter int unsigned DATA_W = RATIO_DATA_W,
  parameter int unsigned IDX_W  = RATIO_IDX_W,
  parameter int unsigned DEPTH  = RATIO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ratio_enable,
  input  logic               ratio_wren,
  input  logic [IDX_W-1:0]   ratio_index,
  input  logic [DATA_W-1:0]  quotient,
  input  logic [IDX_W-1:0]   points,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic               frame_done,
  output logic               overrun,
  output logic [ABORT_W-1:0] abort_cnt
`ifdef RATIO_FRAME_PEAK_EN
  ,
  output logic [DATA_W-1:0]  peak_data,
  output logic [IDX_W-1:0]   peak_index
`endif
);

  state_e            state_q;
  logic [IDX_W-1:0]  pts_q;
  logic [IDX_W-1:0]  rd_addr_q;
  logic              s1_valid_q;
  logic [IDX_W-1:0]  s1_index_q;
  logic [DATA_W-1:0] rd_data;

  logic              idx_ok;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic              fill_done;
  logic              xfer;
  logic              load_out;
  logic              rd_issue;

  always_comb begin
    idx_ok    = (ratio_index != '0) && (ratio_index <= pts_q);
    mem_we    = (state_q == StFill) && ratio_wren && idx_ok;
    mem_waddr = ratio_index - IDX_W'(1);
    fill_done = mem_we && (ratio_index == pts_q);
    xfer      = out_valid && out_ready;
    // Stage 1 is the RAM output; it moves into the output register whenever that frees up.
    load_out  = s1_valid_q && (!out_valid || out_ready);
    rd_issue  = (state_q == StDrain) && (rd_addr_q < pts_q) && (!s1_valid_q || load_out);
  end

  ratio_frame_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (IDX_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (quotient),
    .re    (rd_issue),
    .raddr (rd_addr_q),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pts_q      <= '0;
      rd_addr_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_index_q <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      abort_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ratio_enable) begin
            state_q <= StFill;
            pts_q   <= points;
            overrun <= 1'b0;
          end
        end
        StFill: begin
          // A final write wins over a simultaneous enable drop.
          if (pts_q == '0) begin
            state_q <= StIdle;
          end else if (fill_done) begin
            state_q    <= StDrain;
            rd_addr_q  <= '0;
            s1_valid_q <= 1'b0;
          end else if (!ratio_enable) begin
            state_q <= StIdle;
            if (abort_cnt != '1) begin
              abort_cnt <= abort_cnt + ABORT_W'(1);
            end
          end
        end
        StDrain: begin
          if (ratio_wren) begin
            overrun <= 1'b1;
          end
          if (rd_issue) begin
            rd_addr_q  <= rd_addr_q + IDX_W'(1);
            s1_index_q <= rd_addr_q;
            s1_valid_q <= 1'b1;
          end else if (load_out) begin
            s1_valid_q <= 1'b0;
          end
          if (xfer && out_last) begin
            state_q    <= StIdle;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b1;
            s1_valid_q <= 1'b0;
          end else if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
            out_index <= s1_index_q;
            out_last  <= (s1_index_q == pts_q - IDX_W'(1));
          end else if (xfer) begin
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RATIO_FRAME_PEAK_EN
  logic fill_entry;
  assign fill_entry = (state_q == StIdle) && ratio_enable;

  // Strict compare so ties keep the earliest index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_data  <= '0;
      peak_index <= '0;
    end else if (fill_entry) begin
      peak_data  <= '0;
      peak_index <= '0;
    end else if (mem_we && (quotient > peak_data)) begin
      peak_data  <= quotient;
      peak_index <= mem_waddr;
    end
  end
`endif

endmodule

// File: tb/tb_ratio_frame_buffer.sv
// Directed self-checking bench for ratio_frame_buffer.
module tb_ratio_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ratio_enable = 1'b0;
  logic        ratio_wren = 1'b0;
  logic [10:0] ratio_index = '0;
  logic [11:0] quotient = '0;
  logic [10:0] points = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_data;
  logic [10:0] out_index;
  logic        out_last;
  logic        frame_done;
  logic        overrun;
  logic [7:0]  abort_cnt;
`ifdef RATIO_FRAME_PEAK_EN
  logic [11:0] peak_data;
  logic [10:0] peak_index;
`endif

  ratio_frame_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ratio_enable (ratio_enable),
    .ratio_wren   (ratio_wren),
    .ratio_index  (ratio_index),
    .quotient     (quotient),
    .points       (points),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .abort_cnt    (abort_cnt)
`ifdef RATIO_FRAME_PEAK_EN
    ,
    .peak_data    (peak_data),
    .peak_index   (peak_index)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Transfer monitor, sampled on the falling edge away from DUT updates.
  int   q_data[$];
  int   q_index[$];
  int   q_last[$];
  int   valid_seen = 0;
  logic prev_stall = 1'b0;
  logic [11:0] prev_data = '0;
  logic [10:0] prev_index = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_index", out_index, prev_index);
      end
      if (out_valid) valid_seen <= valid_seen + 1;
      if (out_valid && out_ready) begin
        q_data.push_back(int'(out_data));
        q_index.push_back(int'(out_index));
        q_last.push_back(int'(out_last));
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_index <= out_index;
    end
  end

  int frame_v[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int idx, input int data);
    ratio_wren  = 1'b1;
    ratio_index = 11'(idx);
    quotient    = 12'(data);
    tick();
    ratio_wren  = 1'b0;
  endtask

  // Enter FILL, write frame_v[0..n-1] at indices 1..n, then drop enable.
  task automatic fill_frame(input int n);
    points       = 11'(n);
    ratio_enable = 1'b1;
    tick();
    for (int i = 0; i < n; i++) strobe(i + 1, frame_v[i]);
    ratio_enable = 1'b0;
  endtask

  task automatic run_drain(input logic [3:0] pat, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      out_ready = pat[c[1:0]];
      tick();
      if (frame_done) done = 1'b1;
    end
    out_ready = 1'b1;
    check("drain_done", done, 1);
  endtask

  task automatic check_stream(input string tag, input int n);
    check({tag, "_len"}, q_data.size(), n);
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      check({tag, "_data"}, q_data[i], frame_v[i]);
      check({tag, "_idx"}, q_index[i], i);
      check({tag, "_last"}, q_last[i], (i == n - 1) ? 1 : 0);
    end
    q_data.delete();
    q_index.delete();
    q_last.delete();
  endtask

  int vs0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_abort", abort_cnt, 0);
    check("rst_data", out_data, 0);

    // Basic frame, cycle-exact latency and full throughput.
    frame_v = '{10, 20, 30, 40};
    fill_frame(4);
    check("t1_lat0", out_valid, 0);
    tick();
    check("t1_lat1", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, frame_v[i]);
      check("t1_idx", out_index, i);
      check("t1_last", out_last, (i == 3) ? 1 : 0);
    end
    tick();
    check("t1_valid_drop", out_valid, 0);
    check("t1_done", frame_done, 1);
    tick();
    check("t1_done_pulse", frame_done, 0);
    check("t1_abort", abort_cnt, 0);
    check_stream("t1", 4);

    // Same frame with backpressure 1,0,0,1.
    fill_frame(4);
    run_drain(4'b1001, 60);
    check_stream("t2", 4);

    // Aborted frame, then a clean frame.
    vs0 = valid_seen;
    points = 11'd4;
    ratio_enable = 1'b1;
    tick();
    strobe(1, 1);
    strobe(2, 2);
    ratio_enable = 1'b0;
    repeat (4) tick();
    check("t3_abort", abort_cnt, 1);
    check("t3_novalid", valid_seen - vs0, 0);
    frame_v = '{11, 22, 33, 44};
    fill_frame(4);
    run_drain(4'b1111, 30);
    check_stream("t3", 4);

    // points == 0: straight back to IDLE, no abort even with enable dropping.
    vs0 = valid_seen;
    points = 11'd0;
    ratio_enable = 1'b1;
    tick();
    ratio_enable = 1'b0;
    repeat (3) tick();
    check("t4_abort", abort_cnt, 1);
    check("t4_novalid", valid_seen - vs0, 0);

    // Final write coincides with enable drop: frame completes.
    frame_v = '{7, 8, 0, 0};
    points = 11'd2;
    ratio_enable = 1'b1;
    tick();
    strobe(1, 7);
    ratio_enable = 1'b0;
    strobe(2, 8);
    run_drain(4'b1111, 30);
    check_stream("t5", 2);
    check("t5_abort", abort_cnt, 1);

    // Out-of-range strobes ignored; strobe during DRAIN sets overrun.
    frame_v = '{1, 2, 3, 4};
    points = 11'd4;
    ratio_enable = 1'b1;
    tick();
    strobe(5, 99);
    strobe(0, 98);
    for (int i = 0; i < 4; i++) strobe(i + 1, frame_v[i]);
    ratio_enable = 1'b0;
    strobe(1, 77);
    check("t6_overrun", overrun, 1);
    run_drain(4'b1111, 30);
    check_stream("t6", 4);
    check("t6_overrun_hold", overrun, 1);

    // Next FILL entry clears overrun; reset mid-stream, then fresh frame.
    frame_v = '{5, 6, 7, 8};
    points = 11'd4;
    ratio_enable = 1'b1;
    tick();
    check("t7_overrun_clr", overrun, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(i + 1, frame_v[i]);
    repeat (3) tick();
    check("t7_stall_valid", out_valid, 1);
    check("t7_stall_data", out_data, 5);
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", out_valid, 0);
    check("t7_rst_abort", abort_cnt, 0);
    q_data.delete();
    q_index.delete();
    q_last.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    frame_v = '{50, 60, 70, 80};
    fill_frame(4);
    run_drain(4'b1111, 30);
    check_stream("t7", 4);

`ifdef RATIO_FRAME_PEAK_EN
    frame_v = '{5, 9, 9, 3};
    fill_frame(4);
    run_drain(4'b1111, 30);
    check("peak_data", peak_data, 9);
    check("peak_index", peak_index, 1);
    check_stream("t8", 4);
`endif

    // Abort counter saturates at 255.
    points = 11'd4;
    for (int i = 0; i < 260; i++) begin
      ratio_enable = 1'b1;
      tick();
      ratio_enable = 1'b0;
      tick();
    end
    check("abort_sat", abort_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "bench timeout");
  end

endmodule
